// File: rtl/pwm_tick.sv
// PWM generator advanced by rising edges of an asynchronous slow tick input.
// Duty values arrive through a valid/ready handshake and take effect only at the period wrap.
`timescale 1ns/1ps

module pwm_tick #(
    parameter int bits        = 8,
    parameter int sync_stages = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_in,
    input  logic [bits-1:0] duty,
    input  logic            duty_valid,
    output logic            duty_ready,
    output logic            out,
    output logic            period_end
);

    localparam logic [bits-1:0] cnt_max = '1;

    logic [sync_stages-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;

    logic [bits-1:0]        cnt;
    logic [bits-1:0]        duty_active;
    logic [bits-1:0]        duty_shadow;
    logic                   pending;

    logic                   wrap;
    logic                   xfer;

    // NOTE: state is updated with non-blocking assignments, so every condition
    // below sees the pre-edge value of pending, cnt and the synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], tick_in};
            hist_q <= sync_q[sync_stages-1];
        end
    end

    // One-cycle pulse per rising edge of the synchronised input; falling edges are dropped.
    assign tick = sync_q[sync_stages-1] & ~hist_q;
    assign wrap = tick & (cnt == cnt_max);

    assign duty_ready = ~pending;
    assign xfer       = duty_valid & ~pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A transfer can only happen while pending is clear, so a wrap in the same
    // cycle finds nothing to apply and the new value waits for the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active <= '0;
            duty_shadow <= '0;
            pending     <= 1'b0;
        end else begin
            if (wrap && pending) begin
                duty_active <= duty_shadow;
                pending     <= 1'b0;
            end
            if (xfer) begin
                duty_shadow <= duty;
                pending     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= 1'b0;
            period_end <= 1'b0;
        end else begin
            out        <= (cnt < duty_active);
            period_end <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_tick.sv
// Scoreboard bench for pwm_tick (bits=4): expected per-period high time is queued by the
// stimulus and checked at every period_end; expected tick times are queued by the tick_in driver.
`timescale 1ns/1ps

module tb_pwm_tick;

    localparam int     BITS       = 4;
    localparam int     TICK_P     = 20;                    // clk cycles per tick_in period
    localparam int     PERIOD_CYC = TICK_P * (1 << BITS);  // clk cycles per PWM period
    localparam int     WAIT_MAX   = PERIOD_CYC + 40;
    // tick_in changes 3 ns after a posedge; two sampling edges later the tick is
    // visible at the following negedge: 7 + 10 + 5 ns.
    localparam longint TICK_LAT   = 22;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick_in;
    logic [BITS-1:0] duty;
    logic            duty_valid;
    logic            duty_ready;
    logic            out;
    logic            period_end;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     mode     = 0;   // 0: toggle every cycle, 1: square wave of TICK_P cycles
    longint exp_tick_q[$];
    int     exp_duty_q[$];

    always #5 clk = ~clk;

    pwm_tick #(.bits(BITS), .sync_stages(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .out        (out),
        .period_end (period_end)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // tick_in driver; every rising edge it makes queues the time its tick must appear.
    initial begin
        int phase;
        bit started;
        phase   = 0;
        started = 1'b0;
        tick_in = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (mode == 0) begin
                tick_in = ~tick_in;
            end else if (!started) begin
                started = 1'b1;
                phase   = 0;
                tick_in = 1'b1;
            end else begin
                phase++;
                if (phase == TICK_P / 2) begin
                    phase   = 0;
                    tick_in = ~tick_in;
                    if (tick_in) exp_tick_q.push_back($time + TICK_LAT);
                end
            end
        end
    end

    // Tick monitor: every tick must match the head of the expected-time queue.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_tick_q.size() > 0 && exp_tick_q[0] < $time) begin
                check("tick_missed", $time, exp_tick_q[0]);
                void'(exp_tick_q.pop_front());
            end
            if (dut.tick === 1'b1) begin
                if (exp_tick_q.size() > 0 && exp_tick_q[0] == $time) begin
                    check("tick_time", $time, exp_tick_q[0]);
                    void'(exp_tick_q.pop_front());
                end else begin
                    check("tick_spurious", longint'(dut.tick), 0);
                end
            end
        end
    end

    // PWM monitor: at each period_end compare the window's high time and length.
    initial begin
        int hi;
        int len;
        int e;
        bit fresh;
        hi    = 0;
        len   = 0;
        fresh = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi    = 0;
                len   = 0;
                fresh = 1'b1;
            end else begin
                len++;
                if (out) hi++;
                if (period_end) begin
                    if (exp_duty_q.size() == 0) begin
                        check("duty_exp_underflow", hi, -1);
                    end else begin
                        e = exp_duty_q.pop_front();
                        check("high_cycles", hi, e * TICK_P);
                        if (!fresh) check("period_len", len, PERIOD_CYC);
                    end
                    hi    = 0;
                    len   = 0;
                    fresh = 1'b0;
                end
            end
        end
    end

    task automatic wait_pe(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < WAIT_MAX && !seen; i++) begin
            @(negedge clk);
            if (period_end) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    // Offers v until accepted; with_pe reports period_end in the accepting cycle.
    task automatic send(input logic [BITS-1:0] v, output bit with_pe);
        bit acc;
        acc     = 1'b0;
        with_pe = 1'b0;
        @(negedge clk);
        duty       = v;
        duty_valid = 1'b1;
        for (int i = 0; i < WAIT_MAX && !acc; i++) begin
            if (duty_ready) begin
                acc     = 1'b1;
                with_pe = period_end;
            end
            @(negedge clk);
        end
        duty_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    initial begin
        bit pe;
        bit found;
        rst        = 1'b1;
        duty       = '0;
        duty_valid = 1'b0;

        // Reset with tick_in toggling; switch to the slow wave while still in reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out", out, 0);
            check("rst_ready", duty_ready, 1);
            check("rst_period_end", period_end, 0);
            check("rst_cnt", dut.cnt, 0);
            check("rst_tick", dut.tick, 0);
            if (i == 1) mode = 1;
        end
        // tick_in is high at release, so that edge counts as a tick.
        exp_duty_q.push_back(0);
        rst = 1'b0;
        exp_tick_q.push_back($time + 20);

        // Steady state with duty 5 for two periods.
        exp_duty_q.push_back(5);
        exp_duty_q.push_back(5);
        send(4'd5, pe);
        wait_pe("pe1");
        wait_pe("pe2");

        // Boundary duties: 0 then 15, each visible only after the wrap.
        exp_duty_q.push_back(0);
        send(4'd0, pe);
        wait_pe("pe3");
        exp_duty_q.push_back(15);
        send(4'd15, pe);
        wait_pe("pe4");

        // Back-pressure: 3 is pending, 9 is held until the wrap consumes 3.
        exp_duty_q.push_back(3);
        send(4'd3, pe);
        check("ready_low_after_xfer", duty_ready, 0);
        exp_duty_q.push_back(9);
        send(4'd9, pe);
        check("held_accept_at_wrap", pe, 1);
        wait_pe("pe6");

        // Transfer on the exact wrap cycle: 7 skips the next period.
        exp_duty_q.push_back(9);
        exp_duty_q.push_back(7);
        found = 1'b0;
        for (int i = 0; i < WAIT_MAX && !found; i++) begin
            @(negedge clk);
            if (dut.tick && dut.cnt == 4'hF) begin
                found      = 1'b1;
                duty       = 4'd7;
                duty_valid = 1'b1;
            end
        end
        check("wrap_cycle_found", found, 1);
        @(negedge clk);
        duty_valid = 1'b0;
        check("wrap_xfer_ready", duty_ready, 0);
        check("wrap_xfer_pe", period_end, 1);
        wait_pe("pe8");

        // Reset mid-period at cnt=9 with 12 pending; 12 must be discarded.
        send(4'd12, pe);
        check("pending_before_rst", duty_ready, 0);
        found = 1'b0;
        for (int i = 0; i < WAIT_MAX && !found; i++) begin
            @(negedge clk);
            if (dut.cnt == 4'd9) found = 1'b1;
        end
        check("cnt9_found", found, 1);
        for (int i = 0; i < TICK_P && tick_in; i++) @(negedge clk);
        exp_duty_q.delete();
        exp_duty_q.push_back(0);
        exp_duty_q.push_back(0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_out", out, 0);
            check("mid_rst_ready", duty_ready, 1);
            check("mid_rst_period_end", period_end, 0);
            check("mid_rst_cnt", dut.cnt, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", duty_ready, 1);
        wait_pe("post_rst_pe1");
        wait_pe("post_rst_pe2");
        check("duty_queue_drained", exp_duty_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
